// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter sharing one data-memory slave port
// between NUM_MASTERS requesters, with routing for the single outstanding read.
// Optional build macro DMEM_ARB_PERF_EN adds per-master grant counters and
// a global stall counter (saturating, 32-bit).
module dmem_arbiter #(
   parameter int NUM_MASTERS = 2,
   parameter int WORD_WIDTH  = 32,
   parameter int ADDR_WIDTH  = WORD_WIDTH,
   parameter int DATA_WIDTH  = WORD_WIDTH
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [NUM_MASTERS-1:0]                m_req_i,
   input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]     m_addr_i,
   input  logic [NUM_MASTERS-1:0]                m_we_i,
   input  logic [NUM_MASTERS*(DATA_WIDTH/8)-1:0] m_be_i,
   input  logic [NUM_MASTERS*DATA_WIDTH-1:0]     m_wdata_i,
   output logic [NUM_MASTERS-1:0]                m_gnt_o,
   output logic [NUM_MASTERS-1:0]                m_rvalid_o,
   output logic [DATA_WIDTH-1:0]                 m_rdata_o,
   output logic                                  mem_req_o,
   output logic [ADDR_WIDTH-1:0]                 mem_addr_o,
   output logic                                  mem_we_o,
   output logic [DATA_WIDTH/8-1:0]               mem_be_o,
   output logic [DATA_WIDTH-1:0]                 mem_wdata_o,
   input  logic                                  mem_gnt_i,
   input  logic                                  mem_rvalid_i,
   input  logic [DATA_WIDTH-1:0]                 mem_rdata_i
`ifdef DMEM_ARB_PERF_EN
  ,output logic [NUM_MASTERS*32-1:0]             perf_grant_cnt_o
  ,output logic [31:0]                           perf_stall_cnt_o
`endif
);

   localparam int BE_W  = DATA_WIDTH/8;
   localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

   typedef logic [IDX_W-1:0] idx_t;
   typedef logic [IDX_W:0]   cand_t;
   typedef enum logic {IDLE, WAIT_RD} state_e;

   state_e state_q, state_d;
   idx_t   rr_ptr_q, rr_ptr_d;
   idx_t   owner_q, owner_d;

   idx_t   sel;
   logic   found;
   cand_t  cand;
   cand_t  nxt;
   logic   arb_en;
   logic   grant;

   // Arbitration is open in IDLE and also in the cycle the pending read
   // returns, which gives zero-bubble read-after-read. Held closed in reset.
   assign arb_en = ~rst & ((state_q == IDLE) | mem_rvalid_i);
   assign grant  = mem_req_o & mem_gnt_i;

   // Rotating search: first requester at or above rr_ptr, wrapping.
   always_comb begin
      found = 1'b0;
      sel   = '0;
      cand  = '0;
      for (int k = 0; k < NUM_MASTERS; k++) begin
         cand = {1'b0, rr_ptr_q} + cand_t'(k);
         if (cand >= cand_t'(NUM_MASTERS)) cand = cand - cand_t'(NUM_MASTERS);
         if (!found && m_req_i[cand[IDX_W-1:0]]) begin
            found = 1'b1;
            sel   = cand[IDX_W-1:0];
         end
      end
   end

   // Memory-side mux and master-side grant/read-valid decode.
   always_comb begin
      mem_req_o   = arb_en & found;
      mem_addr_o  = '0;
      mem_we_o    = 1'b0;
      mem_be_o    = '0;
      mem_wdata_o = '0;
      m_gnt_o     = '0;
      m_rvalid_o  = '0;
      m_rdata_o   = rst ? '0 : mem_rdata_i;
      if (mem_req_o) begin
         mem_addr_o  = m_addr_i[sel*ADDR_WIDTH +: ADDR_WIDTH];
         mem_we_o    = m_we_i[sel];
         mem_be_o    = m_be_i[sel*BE_W +: BE_W];
         mem_wdata_o = m_wdata_i[sel*DATA_WIDTH +: DATA_WIDTH];
      end
      if (grant) m_gnt_o[sel] = 1'b1;
      // A returning read is only honoured when one is actually outstanding;
      // anything arriving in IDLE is spurious (e.g. from before a reset).
      if (!rst && state_q == WAIT_RD && mem_rvalid_i) m_rvalid_o[owner_q] = 1'b1;
   end

   // Next-state: pointer advance on grant, read ownership capture.
   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      owner_d  = owner_q;
      nxt      = {1'b0, sel} + cand_t'(1);
      if (state_q == WAIT_RD && mem_rvalid_i) state_d = IDLE;
      if (grant) begin
         rr_ptr_d = (nxt == cand_t'(NUM_MASTERS)) ? '0 : nxt[IDX_W-1:0];
         if (!mem_we_o) begin
            owner_d = sel;
            state_d = WAIT_RD;
         end
      end
   end

   // State, pointer and owner registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         owner_q  <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         owner_q  <= owner_d;
      end
   end

`ifdef DMEM_ARB_PERF_EN
   logic [NUM_MASTERS-1:0][31:0] grant_cnt_q;
   logic [31:0]                  stall_cnt_q;

   // Saturating per-master grant counters and requester-stall counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         for (int i = 0; i < NUM_MASTERS; i++) begin
            if (m_gnt_o[i] && grant_cnt_q[i] != 32'hFFFF_FFFF)
               grant_cnt_q[i] <= grant_cnt_q[i] + 32'd1;
         end
         if ((|m_req_i) && !(|m_gnt_o) && stall_cnt_q != 32'hFFFF_FFFF)
            stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign perf_grant_cnt_o = grant_cnt_q;
   assign perf_stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Round-robin arbiter that shares the single data-memory slave port (req/gnt/rvalid, byte-enabled, WORD_WIDTH) between NUM_MASTERS requesters.
- Typical requesters: core LSU (master 0) and a DMA/debug loader (master 1).
- Sits between the requesters and the MiniSoc data RAM.
- Tracks the one outstanding read so that rvalid/rdata reach the correct requester.

Parameters:
- NUM_MASTERS, 2, number of requesters (2..8).
- ADDR_WIDTH, WORD_WIDTH, address width forwarded to memory.
- DATA_WIDTH, WORD_WIDTH, data width (byte enables = DATA_WIDTH/8).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- m_req_i  in  NUM_MASTERS  per-master request
- m_addr_i  in  NUM_MASTERS*ADDR_WIDTH  packed addresses, master i at slice i
- m_we_i  in  NUM_MASTERS  per-master write enable
- m_be_i  in  NUM_MASTERS*4  packed byte enables
- m_wdata_i  in  NUM_MASTERS*DATA_WIDTH  packed write data
- m_gnt_o  out  NUM_MASTERS  one-hot grant, combinational
- m_rvalid_o  out  NUM_MASTERS  one-hot read-valid, registered path from memory
- m_rdata_o  out  DATA_WIDTH  read data broadcast to all masters, qualified by m_rvalid_o
- mem_req_o  out  1  request to data memory
- mem_addr_o  out  ADDR_WIDTH  selected address
- mem_we_o  out  1  selected write enable
- mem_be_o  out  4  selected byte enables
- mem_wdata_o  out  DATA_WIDTH  selected write data
- mem_gnt_i  in  1  memory grant (may equal mem_req_o combinationally)
- mem_rvalid_i  in  1  read data valid, one or more cycles after a granted read
- mem_rdata_i  in  DATA_WIDTH  read data

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, rr_ptr=0, owner=0.
  - m_gnt_o=0, m_rvalid_o=0, mem_req_o=0; all other outputs 0.
- States: IDLE (no outstanding read) and WAIT_RD (read outstanding, owner latched).
- Selection, combinational, in IDLE:
  - First requesting master found searching from rr_ptr upward, wrapping modulo NUM_MASTERS.
  - mem_* outputs = selected master's fields; mem_req_o = |m_req_i.
  - With no request: mem_req_o=0 and mem_addr/be/wdata/we = 0.
- Grant:
  - m_gnt_o[sel] = mem_gnt_i & mem_req_o; all other bits 0. Zero-latency grant handshake.
  - A master holds req and fields stable until it sees gnt.
- On a granted transaction, rr_ptr <= (sel+1) mod NUM_MASTERS.
- Granted write: stays in IDLE; no rvalid is generated; back-to-back writes allowed every cycle.
- Granted read: owner <= sel; state <= WAIT_RD.
- WAIT_RD:
  - mem_req_o=0 and m_gnt_o=0; all requesters stall.
  - When mem_rvalid_i=1: m_rvalid_o[owner]=1 combinationally, m_rdata_o=mem_rdata_i, state <= IDLE.
- Same-cycle reissue: in the cycle rvalid arrives, the arbiter evaluates IDLE selection, so a new grant may issue in that same cycle. Zero-bubble read-after-read.
- m_rdata_o always mirrors mem_rdata_i; its content is meaningful only when some m_rvalid_o bit is set.
- mem_rvalid_i while IDLE (spurious, or late after reset) is ignored; m_rvalid_o stays 0.
- Reset asserted in WAIT_RD: outstanding read is abandoned; its later rvalid is dropped per the spurious-rvalid rule.
- Requester that drops req before gnt: no state change, no pointer update.
- Single requester: granted every eligible cycle regardless of rr_ptr.
- rr_ptr wraps from NUM_MASTERS-1 to 0.

Optional Feature:
- Macro: DMEM_ARB_PERF_EN.
- With the macro defined, adds outputs:
  - perf_grant_cnt_o (NUM_MASTERS*32): per-master granted-transaction counters.
  - perf_stall_cnt_o (32): counts cycles with any m_req_i=1 and no m_gnt_o bit set.
- All counters are reset to 0 by rst and saturate at 32'hFFFF_FFFF.
- Without the macro: these ports and counters do not exist; functional behaviour is identical.

Test Plan:
- Write, single master: m0 writes addr 0x0000_0010, be 4'b0011, wdata 0xDEAD_BEEF with mem_gnt_i tied to mem_req_o -> m_gnt_o=2'b01 that cycle; mem_* mirror m0; no m_rvalid_o.
- Read routing: m1 reads 0x0000_0020; memory returns rvalid one cycle later with 0x1234_5678 -> m_rvalid_o=2'b10, m_rdata_o=0x1234_5678, no gnt issued during WAIT_RD.
- Round-robin: both masters request reads continuously from reset -> grant order m0, m1, m0, m1; each granted in the cycle its predecessor's rvalid arrives.
- Mid-read reset: reset asserted in WAIT_RD, rvalid arrives two cycles after release -> m_rvalid_o stays 0; state IDLE; next m0 request granted immediately.
- Stall and spurious rvalid: mem_gnt_i held 0 for 3 cycles with m0 requesting -> m_gnt_o=0 and fields unchanged; then mem_rvalid_i pulsed in IDLE -> m_rvalid_o=0.
- With DMEM_ARB_PERF_EN: after the round-robin test (4 grants) -> perf_grant_cnt_o = {2,2}; perf_stall_cnt_o equals the number of WAIT_RD cycles with a pending request.
